// File: rtl/operand_skew_feeder_pkg.sv
// Shared types for the operand skew feeder.
// Datatype, shape and side encodings.
package operand_skew_feeder_pkg;

  typedef enum logic [1:0] {
    DT_FP16,
    DT_INT8,
    DT_INT4,
    DT_FP32
  } datatype_e;

  typedef struct packed {
    datatype_e  dtype;
    logic [1:0] rc;
  } addrgen_t;

  typedef enum logic {
    SIDE_A,
    SIDE_B
  } feeder_side_e;

  localparam logic [1:0] RC_ILLEGAL = 2'b11;

  function automatic logic rc_bad(
    input addrgen_t m
  );
    return m.rc == RC_ILLEGAL;
  endfunction

endpackage

// File: rtl/operand_skew_feeder_unpack.sv
// Per-lane operand unpack/replicate.
// Purely combinational; one instance per lane.
module operand_unpack
  import operand_skew_feeder_pkg::*;
#(
  parameter feeder_side_e SIDE = SIDE_A
) (
  input  addrgen_t    mode,
  input  logic        s,
  input  logic [31:0] d,
  output logic [31:0] data,
  output logic        illegal
);

  logic [15:0] h;
  logic [7:0]  b;

  assign h = s ? d[31:16] : d[15:0];
  assign b = s ? d[15:8] : d[7:0];

  // Select the lane word layout for datatype, shape and side
  always_comb begin
    data    = d;
    illegal = rc_bad(mode);
    if (!illegal) begin
      if (SIDE == SIDE_A) begin
        unique case (mode.dtype)
          DT_FP16: data = {16'h0, h};
          DT_INT8: begin
            if (mode.rc == 2'd1)
              data = s ?
                {d[31:24], d[31:24],
                 d[15:8], d[15:8]} :
                {d[23:16], d[23:16],
                 d[7:0], d[7:0]};
            else if (mode.rc == 2'd2)
              data = {4{b}};
          end
          DT_INT4: begin
            if (mode.rc == 2'd1)
              data = {d[15:8], d[15:8],
                      d[7:0], d[7:0]};
            else if (mode.rc == 2'd2)
              data = {4{d[7:0]}};
          end
          default: data = d;
        endcase
      end else begin
        unique case (mode.dtype)
          DT_FP16: begin
            if (mode.rc != 2'd0)
              data = {16'h0, h};
          end
          DT_INT8: begin
            if (mode.rc == 2'd0)
              data = {4{b}};
            else if (mode.rc == 2'd1)
              data = {2{h}};
          end
          DT_INT4: begin
            if (mode.rc == 2'd0)
              data = {4{d[7:0]}};
            else if (mode.rc == 2'd1)
              data = {2{d[15:12], d[7:4],
                        d[11:8], d[3:0]}};
            else
              data = {d[31:28], d[15:12],
                      d[27:24], d[11:8],
                      d[23:20], d[7:4],
                      d[19:16], d[3:0]};
          end
          default: data = d;
        endcase
      end
    end
  end

endmodule

// File: rtl/operand_skew_feeder.sv
// Operand feeder: address generation, lane skew
// and per-lane unpack toward the PE array.
module operand_skew_feeder
  import operand_skew_feeder_pkg::*;
#(
  parameter int           NUM_LANES = 8,
  parameter int           ADDR_W    = 8,
  parameter int           LEN_W     = 8,
  parameter feeder_side_e SIDE      = SIDE_A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_base,
  input  logic [LEN_W-1:0]       cmd_len,
  input  addrgen_t               cmd_mode,
  input  logic                   stall,
  input  logic                   abort,
  output logic [NUM_LANES-1:0]   sram_re,
  output logic [NUM_LANES-1:0]
               [ADDR_W-3:0]      sram_addr,
  input  logic [NUM_LANES-1:0]
               [31:0]            sram_rdata,
  output logic [NUM_LANES-1:0]   out_valid,
  output logic [NUM_LANES-1:0]   out_last,
  output logic [NUM_LANES-1:0]
               [31:0]            out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   mode_err
);

  localparam int AW1 = ADDR_W - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e              state;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  addrgen_t            mode_q;
  logic                accept;
  logic                lst0;

  logic [NUM_LANES-1:0]          re_l;
  logic [NUM_LANES-1:0]          last_l;
  logic [NUM_LANES-1:0]          sel_l;
  logic [NUM_LANES-1:0]          sel_q;
  logic [NUM_LANES-1:0]          ill;
  logic [NUM_LANES-1:0][AW1-1:0] addr_l;

  logic [NUM_LANES-1:1]          re_p;
  logic [NUM_LANES-1:1]          last_p;
  logic [NUM_LANES-1:1][AW1-1:0] addr_p;

  assign busy      = state != S_IDLE;
  assign cmd_ready = ~busy & ~stall & ~abort;
  assign accept    = cmd_valid & cmd_ready;
  assign lst0      = cnt == len_q - LEN_W'(1);

  assign re_l   = {re_p, state == S_ISSUE};
  assign last_l = {last_p, lst0};
  assign addr_l = {addr_p, addr_q[ADDR_W-1:1]};

  assign sram_re = re_l & {NUM_LANES{~stall}};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign sram_addr[g] = addr_l[g][AW1-1:1];
    assign sel_l[g]     = addr_l[g][0];

    operand_unpack #(
      .SIDE (SIDE)
    ) u_unpack (
      .mode    (mode_q),
      .s       (sel_q[g]),
      .d       (sram_rdata[g]),
      .data    (out_data[g]),
      .illegal (ill[g])
    );
  end

  // Command FSM, beat/address counters, done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      len_q  <= '0;
      cnt    <= '0;
      addr_q <= '0;
      mode_q <= '0;
      done   <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else if (stall) begin
      done <= 1'b0;
    end else begin
      done <= re_l[NUM_LANES-1] &
              last_l[NUM_LANES-1];
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            len_q  <= cmd_len;
            mode_q <= cmd_mode;
            addr_q <= cmd_base;
            cnt    <= '0;
            if (cmd_len == '0)
              done <= 1'b1;
            else
              state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          addr_q <= addr_q + ADDR_W'(1);
          cnt    <= cnt + LEN_W'(1);
          if (lst0)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_valid[NUM_LANES-1] &
              out_last[NUM_LANES-1])
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Lane skew shift and registered lane outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_p      <= '0;
      last_p    <= '0;
      addr_p    <= '0;
      out_valid <= '0;
      out_last  <= '0;
      sel_q     <= '0;
    end else if (abort) begin
      re_p      <= '0;
      last_p    <= '0;
      out_valid <= '0;
      out_last  <= '0;
    end else if (!stall) begin
      re_p      <= re_l[NUM_LANES-2:0];
      last_p    <= last_l[NUM_LANES-2:0];
      addr_p    <= addr_l[NUM_LANES-2:0];
      out_valid <= re_l;
      out_last  <= re_l & last_l;
      sel_q     <= sel_l;
    end
  end

  // Sticky flag for an illegal shape code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mode_err <= 1'b0;
    else if ((accept & rc_bad(cmd_mode)) |
             (busy & |ill))
      mode_err <= 1'b1;
  end

endmodule
